// File: rtl/div32_seq.sv
// Sequential non-restoring divider for DIV/DIVU: one quotient bit per clock,
// fixed 33-cycle latency from accepted Start to a one-cycle Ready pulse.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             Start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Busy,
  output logic             Ready,
  output logic             DivZero,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] ymag_q, ymag_d;
  logic [WIDTH-1:0] xorig_q, xorig_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             yzero_q, yzero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             rdy_q, rdy_d;

  // Single shared 33-bit adder; subtraction is invert-and-carry-in.
  logic [WIDTH:0]   add_a, add_b, sum;
  logic             add_sub;
  logic [WIDTH-1:0] xmag, ymag_in, rem_fix, quot_s, rem_s;

  always_comb begin
    add_sub = 1'b0;
    add_a   = rem_q;
    if (state_q == S_RUN) begin
      add_a   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      add_sub = ~rem_q[WIDTH];
    end
    add_b = add_sub ? ~{1'b0, ymag_q} : {1'b0, ymag_q};
    sum   = add_a + add_b + {{WIDTH{1'b0}}, add_sub};
  end

  always_comb begin
    xmag    = (Sign && X[WIDTH-1]) ? (~X + {{(WIDTH-1){1'b0}}, 1'b1}) : X;
    ymag_in = (Sign && Y[WIDTH-1]) ? (~Y + {{(WIDTH-1){1'b0}}, 1'b1}) : Y;
    rem_fix = rem_q[WIDTH] ? sum[WIDTH-1:0] : rem_q[WIDTH-1:0];
    quot_s  = qneg_q ? (~dvd_q + {{(WIDTH-1){1'b0}}, 1'b1}) : dvd_q;
    rem_s   = rneg_q ? (~rem_fix + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_fix;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    ymag_d  = ymag_q;
    xorig_d = xorig_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    yzero_d = yzero_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    rdy_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          rem_d   = '0;
          dvd_d   = xmag;
          ymag_d  = ymag_in;
          xorig_d = X;
          qneg_d  = (X[WIDTH-1] ^ Y[WIDTH-1]) & Sign;
          rneg_d  = X[WIDTH-1] & Sign;
          yzero_d = (Y == '0);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Quotient bits shift into the vacated low end of the dividend.
        rem_d = sum;
        dvd_d = {dvd_q[WIDTH-2:0], ~sum[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        rem_d = {1'b0, rem_fix};
        if (yzero_q) begin
          q_d  = '1;
          r_d  = xorig_q;
          dz_d = 1'b1;
        end else begin
          q_d  = quot_s;
          r_d  = rem_s;
          dz_d = 1'b0;
        end
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      ymag_q  <= '0;
      xorig_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      yzero_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      ymag_q  <= ymag_d;
      xorig_q <= xorig_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      yzero_q <= yzero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      rdy_q   <= rdy_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign DivZero     = dz_q;
  assign Ready       = rdy_q;
  assign Busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: scenario tasks drive operations, a Ready-triggered
// scoreboard compares Q/R/DivZero against a reference model queue.
module tb_div32_seq;

  logic        clk;
  logic        clrn;
  logic        Start;
  logic        Sign;
  logic [31:0] X;
  logic [31:0] Y;
  logic [31:0] Q;
  logic [31:0] R;
  logic        Busy;
  logic        Ready;
  logic        DivZero;
  logic [1:0]  dbg_state;

  int tests_run;
  int tests_failed;

  logic [64:0] exp_q[$];
  logic [31:0] last_q;
  logic [31:0] last_r;

  div32_seq #(.WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .Start(Start), .Sign(Sign), .X(X), .Y(Y),
    .Q(Q), .R(R), .Busy(Busy), .Ready(Ready), .DivZero(DivZero),
    .dbg_state_o(dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- reference model: {DivZero, Q, R} ----
  function automatic logic [64:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r;
    if (y == 32'd0) return {1'b1, 32'hFFFF_FFFF, x};
    if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end
    end else begin
      q = x / y;
      r = x % y;
    end
    return {1'b0, q, r};
  endfunction

  // ---- scoreboard ----
  always @(negedge clk) begin
    if (clrn && Ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_ready: got Q=%h R=%h DZ=%b, no result expected", Q, R, DivZero);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({DivZero, Q, R} !== e) begin
          tests_failed++;
          $display("FAIL result: got DZ=%b Q=%h R=%h, expected DZ=%b Q=%h R=%h",
                   DivZero, Q, R, e[64], e[63:32], e[31:0]);
        end
        last_q = e[63:32];
        last_r = e[31:0];
      end
    end
  end

  // ---- driver tasks ----
  task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    Sign  = s;
    X     = x;
    Y     = y;
    Start = 1'b1;
    exp_q.push_back(model(s, x, y));
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Waits (bounded) for Ready; lat counts negedges, busy_n counts Busy samples.
  task automatic wait_ready(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (Busy) busy_n++;
      if (Ready) return;
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset;
    clrn = 1'b0; Start = 1'b0; Sign = 1'b0; X = '0; Y = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({Q, R, Busy, Ready, DivZero} !== 67'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got Q=%h R=%h B=%b Rdy=%b DZ=%b, expected all 0",
               Q, R, Busy, Ready, DivZero);
    end
    clrn = 1'b1;
  endtask

  task automatic test_ops;
    logic        s_t[10];
    logic [31:0] x_t[10];
    logic [31:0] y_t[10];
    int lat, bn;
    s_t[0] = 0; x_t[0] = 32'd100;        y_t[0] = 32'd7;
    s_t[1] = 1; x_t[1] = 32'hFFFF_FFF9;  y_t[1] = 32'd2;
    s_t[2] = 1; x_t[2] = 32'd7;          y_t[2] = 32'hFFFF_FFFE;
    s_t[3] = 0; x_t[3] = 32'hFFFF_FFFF;  y_t[3] = 32'h8000_0000;
    s_t[4] = 1; x_t[4] = 32'h8000_0000;  y_t[4] = 32'hFFFF_FFFF;
    s_t[5] = 1; x_t[5] = 32'hFFFF_FF9C;  y_t[5] = 32'hFFFF_FFF9;
    for (int i = 6; i < 10; i++) begin
      s_t[i] = 1'($urandom_range(0, 1));
      x_t[i] = $urandom;
      y_t[i] = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
    end
    for (int i = 0; i < 10; i++) begin
      launch(s_t[i], x_t[i], y_t[i]);
      tests_run++;
      if (Busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_after_accept op%0d: got %b, expected 1", i, Busy);
      end
      wait_ready(lat, bn);
      tests_run++;
      if (lat !== 33 || bn !== 32) begin
        tests_failed++;
        $display("FAIL latency op%0d: got lat=%0d busy=%0d, expected lat=33 busy=32", i, lat, bn);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bn;
    launch(1'b0, 32'd5, 32'd0);
    wait_ready(lat, bn);
    launch(1'b1, 32'd5, 32'd0);
    wait_ready(lat, bn);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL div_zero_latency: got %0d, expected 33", lat);
    end
    launch(1'b0, 32'd9, 32'd3);
    wait_ready(lat, bn);
  endtask

  task automatic test_start_ignored;
    int lat, bn, extra;
    launch(1'b0, 32'd1000, 32'd33);
    repeat (5) @(negedge clk);
    Sign = 1'b1; X = 32'd77; Y = 32'd5; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_ready(lat, bn);
    tests_run++;
    if (lat + 6 !== 33) begin
      tests_failed++;
      $display("FAIL ignored_start_latency: got %0d, expected 33", lat + 6);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (Ready) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL ignored_start_extra_ready: got %0d pulses, expected 0", extra);
    end
  endtask

  task automatic test_hold;
    int bad, lat, bn;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (Q !== last_q || R !== last_r) bad++;
    end
    launch(1'b1, 32'hFFFF_F000, 32'd17);
    repeat (20) begin
      @(negedge clk);
      if (Q !== last_q || R !== last_r) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL hold_qr: got %0d unstable samples, expected 0", bad);
    end
    wait_ready(lat, bn);
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    @(negedge clk);
    Sign = 1'b0; X = 32'd123456; Y = 32'd100; Start = 1'b1;
    exp_q.push_back(model(1'b0, 32'd123456, 32'd100));
    @(negedge clk);
    Sign = 1'b1; X = 32'hFFFF_FF00; Y = 32'd7;
    exp_q.push_back(model(1'b1, 32'hFFFF_FF00, 32'd7));
    wait_ready(lat, bn);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL b2b_first_latency: got %0d, expected 33", lat);
    end
    @(negedge clk);
    Start = 1'b0;
    tests_run++;
    if (Busy !== 1'b1 || Ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: got Busy=%b Ready=%b, expected 1/0", Busy, Ready);
    end
    wait_ready(lat, bn);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL b2b_second_latency: got %0d, expected 33", lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bn, extra;
    launch(1'b0, 32'd999, 32'd4);
    repeat (10) @(negedge clk);
    #2 clrn = 1'b0;
    void'(exp_q.pop_back());
    #1;
    tests_run++;
    if ({Q, R, Busy, Ready, DivZero} !== 67'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got Q=%h R=%h B=%b Rdy=%b DZ=%b, expected all 0",
               Q, R, Busy, Ready, DivZero);
    end
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (Ready || Busy) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_activity: got %0d active cycles, expected 0", extra);
    end
    launch(1'b0, 32'd9, 32'd3);
    wait_ready(lat, bn);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL post_reset_latency: got %0d, expected 33", lat);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    last_q = '0;
    last_r = '0;
    test_reset();
    test_ops();
    test_div_zero();
    test_start_ignored();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
